// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: oper encodings, FSM states,
// iteration count and an operand magnitude helper.
package mdu_pkg;

    localparam logic [1:0] MDU_MUL  = 2'd0;
    localparam logic [1:0] MDU_DIV  = 2'd1;
    localparam logic [1:0] MDU_MTHI = 2'd2;
    localparam logic [1:0] MDU_MTLO = 2'd3;

    localparam int unsigned MDU_ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } mdu_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// quotient/remainder present the values that result from the current step.
module mdu_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dsr;
    logic [32:0] trial;
    logic [31:0] quo_nxt;
    logic [31:0] rem_nxt;

    // Partial remainder stays below the divisor, so bit 32 of the trial is the borrow.
    assign trial = {rem, quo[31]} - {1'b0, dsr};

    always_comb begin
        quo_nxt = {quo[30:0], 1'b0};
        rem_nxt = {rem[30:0], quo[31]};
        if (!trial[32]) begin
            quo_nxt = {quo[30:0], 1'b1};
            rem_nxt = trial[31:0];
        end
    end

    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dsr <= divisor;
        end else if (step) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit (MULT[U], DIV[U], MTHI, MTLO) with iterative datapaths.
// Define MDU_FAST_MUL_EN for a combinational multiplier (start-to-done latency 2).
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  oper,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  state;
    mdu_state_t  state_next;
    logic [4:0]  cnt;
    logic        iter_last;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] a_keep;
    logic [31:0] mcand;
    logic [63:0] prod;
    logic [63:0] product_mag;
    logic [63:0] prod_signed;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;
    logic        op_mul;
    logic        op_div;

    assign op_mul    = start && (oper == MDU_MUL);
    assign op_div    = start && (oper == MDU_DIV);
    assign iter_last = (cnt == 5'(MDU_ITERS - 1));

`ifdef MDU_FAST_MUL_EN
    assign product_mag = {32'b0, prod[31:0]} * {32'b0, mcand};
`else
    logic [32:0] mul_sum;

    // prod = {partial sum, remaining multiplier bits}; the last step is written straight to HI/LO.
    assign mul_sum     = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    assign product_mag = {mul_sum, prod[31:1]};
`endif

    assign prod_signed = (a_neg ^ b_neg) ? (~product_mag + 64'd1) : product_mag;
    assign quo_signed  = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
    assign rem_signed  = a_neg ? (~rem + 32'd1) : rem;

    mdu_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      ((state == S_IDLE) && op_div),
        .step      (state == S_DIV),
        .dividend  (mag32(a, sign)),
        .divisor   (mag32(b, sign)),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (op_mul) begin
                    state_next = S_MUL;
                end else if (op_div) begin
                    state_next = S_DIV;
                end
            end
            S_MUL: begin
                busy = 1'b1;
`ifdef MDU_FAST_MUL_EN
                state_next = S_DONE;
`else
                if (iter_last) begin
                    state_next = S_DONE;
                end
`endif
            end
            S_DIV: begin
                busy = 1'b1;
                if (iter_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            div_zero <= 1'b0;
            a_keep   <= '0;
            mcand    <= '0;
            prod     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        case (oper)
                            MDU_MTHI: hi <= a;
                            MDU_MTLO: lo <= a;
                            default: begin
                                a_neg    <= sign & a[31];
                                b_neg    <= sign & b[31];
                                div_zero <= (b == '0);
                                a_keep   <= a;
                                mcand    <= mag32(b, sign);
                                prod     <= {32'b0, mag32(a, sign)};
                                cnt      <= '0;
                            end
                        endcase
                    end
                end
                S_MUL: begin
`ifdef MDU_FAST_MUL_EN
                    {hi, lo} <= prod_signed;
`else
                    if (iter_last) begin
                        {hi, lo} <= prod_signed;
                    end else begin
                        prod <= product_mag;
                        cnt  <= cnt + 5'd1;
                    end
`endif
                end
                S_DIV: begin
                    if (iter_last) begin
                        if (div_zero) begin
                            hi <= a_keep;
                            lo <= '1;
                        end else begin
                            hi <= rem_signed;
                            lo <= quo_signed;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
